// File: rtl/sa_feeder.sv
// Upstream sequencer for the systolic array: buffers B then A from a serial stream,
// then drives B rows (reversed, weight latch on the last) and A rows, and waits for the results.
module sa_feeder #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    input  logic [WIDTH-1:0]        i_data,
    output logic                    o_rdy,
    output logic                    o_we,
    output logic                    o_a_vld,
    output logic                    o_c_vld,
    output logic [SIZE*WIDTH-1:0]   o_a_rows,
    input  logic                    i_sa_c_vld,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int NELEM = 2 * SIZE * SIZE;
    localparam int EW    = $clog2(NELEM + 1);
    localparam int RW    = $clog2(SIZE + 1);
    localparam int AW    = (NELEM > 1) ? $clog2(NELEM) : 1;

    typedef enum logic [1:0] {FILL, LOAD_B, PASS_A, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [EW-1:0]           elem_cnt_q, elem_cnt_d;
    logic [RW-1:0]           row_cnt_q, row_cnt_d;
    logic [RW-1:0]           res_cnt_q, res_cnt_d;
    logic                    we_q, we_d;
    logic                    a_vld_q, a_vld_d;
    logic                    c_vld_q, c_vld_d;
    logic                    done_q, done_d;
    logic [SIZE*WIDTH-1:0]   a_rows_q, a_rows_d;
    logic [WIDTH-1:0]        buf_q [NELEM];
    logic                    wr_en;
    int                      rd_base;

    assign o_rdy    = (state_q == FILL);
    assign o_busy   = (state_q != FILL);
    assign o_we     = we_q;
    assign o_a_vld  = a_vld_q;
    assign o_c_vld  = c_vld_q;
    assign o_a_rows = a_rows_q;
    assign o_done   = done_q;
    assign wr_en    = i_vld && (state_q == FILL);

    // State register mirrors the beat currently on the bus; outputs for the
    // next beat are computed here and registered.
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        row_cnt_d  = row_cnt_q;
        res_cnt_d  = res_cnt_q;
        we_d       = 1'b0;
        a_vld_d    = 1'b0;
        c_vld_d    = 1'b0;
        done_d     = 1'b0;
        rd_base    = 0;
        a_rows_d   = '0;

        if ((state_q == PASS_A || state_q == DRAIN) && i_sa_c_vld && res_cnt_q != RW'(SIZE))
            res_cnt_d = res_cnt_q + RW'(1);

        case (state_q)
            FILL: begin
                if (i_vld) begin
                    if (elem_cnt_q == EW'(NELEM - 1)) begin
                        elem_cnt_d = '0;
                        state_d    = LOAD_B;
                        row_cnt_d  = '0;
                        a_vld_d    = 1'b1;
                        we_d       = (SIZE == 1);
                        rd_base    = (SIZE - 1) * SIZE;
                    end else begin
                        elem_cnt_d = elem_cnt_q + EW'(1);
                    end
                end
            end
            LOAD_B: begin
                a_vld_d = 1'b1;
                if (row_cnt_q == RW'(SIZE - 1)) begin
                    state_d   = PASS_A;
                    row_cnt_d = '0;
                    c_vld_d   = 1'b1;
                    rd_base   = SIZE * SIZE;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                    we_d      = (row_cnt_q == RW'(SIZE - 2));
                    rd_base   = (SIZE - 2 - int'(row_cnt_q)) * SIZE;
                end
            end
            PASS_A: begin
                if (row_cnt_q == RW'(SIZE - 1)) begin
                    state_d   = DRAIN;
                    row_cnt_d = '0;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                    a_vld_d   = 1'b1;
                    c_vld_d   = 1'b1;
                    rd_base   = SIZE * SIZE + (int'(row_cnt_q) + 1) * SIZE;
                end
            end
            DRAIN: begin
                if (res_cnt_d == RW'(SIZE)) begin
                    done_d    = 1'b1;
                    res_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        if (a_vld_d) begin
            for (int j = 0; j < SIZE; j++)
                a_rows_d[j*WIDTH +: WIDTH] = buf_q[AW'(rd_base + j)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            elem_cnt_q <= '0;
            row_cnt_q  <= '0;
            res_cnt_q  <= '0;
            we_q       <= 1'b0;
            a_vld_q    <= 1'b0;
            c_vld_q    <= 1'b0;
            done_q     <= 1'b0;
            a_rows_q   <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            row_cnt_q  <= row_cnt_d;
            res_cnt_q  <= res_cnt_d;
            we_q       <= we_d;
            a_vld_q    <= a_vld_d;
            c_vld_q    <= c_vld_d;
            done_q     <= done_d;
            a_rows_q   <= a_rows_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en)
            buf_q[AW'(elem_cnt_q)] <= i_data;
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: table of matrix pairs plus random pairs, checked against
// a matrix-level model of the beat order and of the array's products.
module tb_sa_feeder;

    localparam int W  = 16;
    localparam int S  = 3;
    localparam int NM = S * S;
    localparam int MB = NM * W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_vld = 1'b0;
    logic [W-1:0]     i_data = '0;
    logic             o_rdy, o_we, o_a_vld, o_c_vld, o_busy, o_done;
    logic [S*W-1:0]   o_a_rows;
    logic             i_sa_c_vld = 1'b0;

    sa_feeder #(.WIDTH(W), .SIZE(S)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_data(i_data), .o_rdy(o_rdy),
        .o_we(o_we), .o_a_vld(o_a_vld), .o_c_vld(o_c_vld), .o_a_rows(o_a_rows),
        .i_sa_c_vld(i_sa_c_vld), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MB-1:0] b;
        logic [MB-1:0] a;
        int            gap_max;
        bit            hold;
        logic [W-1:0]  exp_lane0;
        int            exp_c00;
    } vec_t;

    int             n_pass = 0;
    int             n_total = 0;
    logic [S*W-1:0] cap [2*S];
    int             c_got [S][S];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] el(input logic [MB-1:0] m, input int k);
        return m[k*W +: W];
    endfunction

    function automatic logic [S*W-1:0] row_of(input logic [MB-1:0] m, input int r);
        logic [S*W-1:0] v;
        for (int j = 0; j < S; j++) v[j*W +: W] = el(m, r*S + j);
        return v;
    endfunction

    task automatic drive_stream(input logic [MB-1:0] b, input logic [MB-1:0] a, input int gap_max);
        for (int k = 0; k < 2*NM; k++) begin
            int idle;
            idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < idle; g++) begin
                i_vld = 1'b0;
                i_data = W'($urandom);
                step();
            end
            i_vld = 1'b1;
            i_data = (k < NM) ? el(b, k) : el(a, k - NM);
            step();
        end
    endtask

    task automatic run_pair(input logic [MB-1:0] b, input logic [MB-1:0] a,
                            input int gap_max, input bit hold, input int early);
        logic [S*W-1:0] exp_row;
        int npulse;
        drive_stream(b, a, gap_max);
        i_vld = hold;
        i_data = W'($urandom);
        chk("rdy_after_last", {63'd0, o_rdy}, 64'd0);
        chk("busy_load", {63'd0, o_busy}, 64'd1);
        for (int k = 0; k < 2*S; k++) begin
            exp_row = (k < S) ? row_of(b, S-1-k) : row_of(a, k-S);
            chk("beat_avld", {63'd0, o_a_vld}, 64'd1);
            chk("beat_we", {63'd0, o_we}, {63'd0, k == S-1});
            chk("beat_cvld", {63'd0, o_c_vld}, {63'd0, k >= S});
            chk("beat_rows", 64'(o_a_rows), 64'(exp_row));
            if (hold) chk("rdy_busy", {63'd0, o_rdy}, 64'd0);
            cap[k] = o_a_rows;
            if (hold) i_data = W'($urandom);
            i_sa_c_vld = (early > 0) && (k == S+1);
            step();
        end
        i_sa_c_vld = 1'b0;
        chk("drain_avld", {63'd0, o_a_vld}, 64'd0);
        chk("drain_rows", 64'(o_a_rows), 64'd0);
        chk("drain_cvld_we", {62'd0, o_c_vld, o_we}, 64'd0);
        // Array model: weights are the reversed B beats, products from the A beats.
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                int sum_got, sum_ref;
                sum_got = 0;
                sum_ref = 0;
                for (int m = 0; m < S; m++) begin
                    sum_got += int'($signed(cap[S+r][m*W +: W])) * int'($signed(cap[S-1-m][c*W +: W]));
                    sum_ref += int'($signed(el(a, r*S+m))) * int'($signed(el(b, m*S+c)));
                end
                c_got[r][c] = sum_got;
                chk("c_elem", 64'(sum_got), 64'(sum_ref));
            end
        npulse = S - early;
        for (int p = 0; p < npulse; p++) begin
            int idle;
            idle = int'($urandom_range(2, 0));
            for (int g = 0; g < idle; g++) begin
                if (hold) i_data = W'($urandom);
                step();
            end
            i_sa_c_vld = 1'b1;
            step();
            i_sa_c_vld = 1'b0;
            if (p < npulse-1) begin
                chk("done_early", {63'd0, o_done}, 64'd0);
                chk("rdy_drain", {63'd0, o_rdy}, 64'd0);
            end else begin
                chk("done_pulse", {63'd0, o_done}, 64'd1);
                chk("rdy_after_done", {63'd0, o_rdy}, 64'd1);
                chk("busy_after_done", {63'd0, o_busy}, 64'd0);
                i_vld = 1'b0;
            end
        end
        step();
        chk("done_once", {63'd0, o_done}, 64'd0);
    endtask

    initial begin
        vec_t tbl [5];
        logic [MB-1:0] seq, neg, diag, rb, ra;
        for (int k = 0; k < NM; k++) begin
            seq[k*W +: W]  = W'(k + 1);
            neg[k*W +: W]  = 16'hFFFF;
            diag[k*W +: W] = (k % (S+1) == 0) ? 16'h7FFF : 16'h0000;
        end
        tbl[0] = '{seq, seq, 0, 1'b0, 16'd7, 30};
        tbl[1] = '{seq, seq, 3, 1'b0, 16'd7, 30};
        tbl[2] = '{seq, seq, 0, 1'b1, 16'd7, 30};
        tbl[3] = '{neg, diag, 1, 1'b0, 16'hFFFF, -32767};
        tbl[4] = '{neg, diag, 0, 1'b0, 16'hFFFF, -32767};

        #12;
        chk("rst_rdy", {63'd0, o_rdy}, 64'd1);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_outs", {60'd0, o_we, o_a_vld, o_c_vld, o_done}, 64'd0);
        chk("rst_rows", 64'(o_a_rows), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_pair(tbl[i].b, tbl[i].a, tbl[i].gap_max, tbl[i].hold, 0);
            chk("tbl_lane0", 64'(cap[0][W-1:0]), 64'(tbl[i].exp_lane0));
            chk("tbl_c00", 64'(c_got[0][0]), 64'(tbl[i].exp_c00));
            if (i == 0) begin
                chk("c_row0_2", 64'(c_got[0][2]), 64'd42);
                chk("c_row1_1", 64'(c_got[1][1]), 64'd81);
                chk("c_row2_2", 64'(c_got[2][2]), 64'd150);
            end
            if (i == 4) chk("diag_lane", 64'(cap[S+1][2*W-1:W]), 64'h7FFF);
        end

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NM; k++) begin
                rb[k*W +: W] = W'($urandom);
                ra[k*W +: W] = W'($urandom);
            end
            run_pair(rb, ra, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                     int'($urandom_range(1, 0)));
        end

        // Reset during the second LOAD_B beat.
        drive_stream(rb, ra, 0);
        i_vld = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_avld", {63'd0, o_a_vld}, 64'd0);
        chk("rst_mid_we", {63'd0, o_we}, 64'd0);
        chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
        #3 rst_n = 1'b1;
        step();
        chk("rst_mid_rdy", {63'd0, o_rdy}, 64'd1);

        // Partial load discarded by reset; stray results in FILL ignored.
        for (int k = 0; k < 5; k++) begin
            i_vld = 1'b1;
            i_data = W'($urandom);
            step();
        end
        i_vld = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        i_sa_c_vld = 1'b1;
        step();
        step();
        i_sa_c_vld = 1'b0;
        chk("spurious_done", {63'd0, o_done}, 64'd0);
        run_pair(seq, seq, 0, 1'b0, 0);
        chk("after_rst_c22", 64'(c_got[2][2]), 64'd150);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Upstream sequencer for the systolic array top (`sa_top`).
- Accepts a serial element stream through a valid/ready handshake: matrix B first, then matrix A, each row-major.
- Buffers both matrices, then drives the array's exact load/compute sequence: B rows in reverse order with write-enable on the last row, then A rows back-to-back.
- Waits for SIZE result rows from the array, pulses done, and returns to accepting the next matrix pair.

Parameters:
- WIDTH, 16, element width in bits (signed two's complement, passed through unmodified).
- SIZE, 3, array dimension; each matrix is SIZE x SIZE.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- i_vld  input  1  input element valid.
- i_data  input  WIDTH  input element.
- o_rdy  output  1  feeder can accept an element.
- o_we  output  1  to array i_we (weight latch on last B row).
- o_a_vld  output  1  to array i_a_vld.
- o_c_vld  output  1  to array i_c_vld (compute-valid for A rows).
- o_a_rows  output  SIZE*WIDTH  to array i_a_rows; lane j = bits [j*WIDTH +: WIDTH] = column j.
- i_sa_c_vld  input  1  from array o_c_vld (one pulse per result row).
- o_busy  output  1  high in any state other than FILL.
- o_done  output  1  one-cycle pulse when the last result row has been seen.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL; element counter, row counter and result counter = 0.
  - o_we, o_a_vld, o_c_vld, o_busy, o_done = 0; o_a_rows = 0; o_rdy = 1.
  - Buffer contents are don't-care.
- Buffer: 2*SIZE*SIZE elements. Index 0..SIZE*SIZE-1 holds B, the remainder holds A, both row-major.
- o_rdy = (state==FILL), combinational from state. An element is accepted on a cycle with i_vld && o_rdy.
- FILL:
  - Each accepted element is written to buffer[elem_cnt] and elem_cnt increments.
  - Gaps in i_vld are allowed.
  - On acceptance of element 2*SIZE*SIZE-1: elem_cnt <= 0, go to LOAD_B.
- LOAD_B: exactly SIZE cycles, k = 0..SIZE-1.
  - o_a_vld = 1.
  - o_a_rows = B row SIZE-1-k.
  - o_we = 1 only when k == SIZE-1.
  - o_c_vld = 0.
  - After k = SIZE-1, go to PASS_A.
- PASS_A: exactly SIZE cycles, k = 0..SIZE-1.
  - o_a_vld = 1, o_c_vld = 1, o_we = 0.
  - o_a_rows = A row k.
  - No bubbles between the last LOAD_B beat and the first PASS_A beat, or between PASS_A beats.
  - After the last beat, go to DRAIN.
- DRAIN:
  - o_a_vld = o_c_vld = o_we = 0; o_a_rows = 0.
  - Count i_sa_c_vld pulses. i_sa_c_vld is also counted if it arrives during PASS_A.
  - On the cycle the count reaches SIZE: o_done = 1 for exactly one cycle, count clears, go to FILL.
- Timing: all array-facing outputs are registered.
  - The first LOAD_B beat appears on the cycle after the final element handshake.
  - Total from final handshake to first A beat is SIZE+1 cycles.
- Whenever o_a_vld = 0, o_a_rows = 0 (no stale data on the bus).
- In LOAD_B, PASS_A and DRAIN, i_vld is ignored (o_rdy = 0). No element is lost or buffered.
- Reset mid-operation (any state): immediate return to the reset values. A partially loaded matrix is discarded; the next stream starts at B[0][0].
- Spurious i_sa_c_vld in FILL is ignored and does not change the counter.
- Width: data is copied bit-exact; no arithmetic on elements. Counter widths are $clog2(2*SIZE*SIZE+1) and $clog2(SIZE+1).

Test Plan:
- Basic sequence, SIZE=3.
  - Stimulus: stream B = 1..9 then A = 1..9, i_vld held high.
  - Required: o_rdy drops after the 18th handshake.
  - Next cycles: o_a_rows = [7,8,9], [4,5,6], [1,2,3], with o_we only on [1,2,3].
  - Then [1,2,3], [4,5,6], [7,8,9], with o_c_vld = 1 on all three.
  - Then o_a_vld = 0 and o_a_rows = 0.
- Integration with the array.
  - Stimulus: same stream as above, feeder connected to the array.
  - Required: captured C rows [30,36,42], [66,81,96], [102,126,150].
  - o_done pulses once, one cycle after the 3rd i_sa_c_vld; o_rdy = 1 the next cycle.
- Input gaps.
  - Stimulus: toggle i_vld every other cycle, random idle runs of 0..3 cycles.
  - Required: array-facing sequence identical to the basic test; no dropped or duplicated elements.
- Busy backpressure.
  - Stimulus: hold i_vld = 1 with changing i_data through LOAD_B, PASS_A and DRAIN.
  - Required: o_rdy = 0 and the buffer is unchanged.
  - The next pair starts from the first element presented after o_rdy rises.
- Reset mid-operation.
  - Stimulus: assert rst_n = 0 during the 2nd LOAD_B beat.
  - Required: o_a_vld, o_we and o_busy are 0 asynchronously; o_rdy = 1 after release.
  - A fresh 18-element stream produces the correct sequence.
- Signed and back-to-back runs.
  - Stimulus: B = -1 everywhere, A = 0x7FFF on the diagonal; two full runs consecutively.
  - Required: lanes carry 16'hFFFF and 16'h7FFF bit-exact.
  - The second run is unaffected by the first; o_done pulses once per run.
